oled_stream_ctrl: RTL and testbench
===================================

Name: oled_stream_ctrl

Overview:
Next-generation SSD1306 controller FSM for the OLED subsystem, sitting between the byte-level i2c_master and a framebuffer BRAM. It runs the power-up init sequence and then streams full frames from BRAM on request. Panel size, device address and retry policy are parametrised. Retry on NACK is handled internally.

Parameters:
I2C_ADDR, 7'h3C, 7-bit slave address; address byte = {I2C_ADDR,1'b0}.
COLS, 128, panel columns.
PAGES, 8, panel pages (8 rows each).
FB_AW, 10, BRAM address width; COLS*PAGES must be <= 2**FB_AW.
MAX_RETRY, 3, transaction retries after a NACK before declaring error.
REFRESH_CYCLES, 1_666_666, auto-refresh period in clk cycles (optional feature only).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
refresh_req  in  1  one-cycle pulse: stream one frame
i2c_start  out  1  one-cycle pulse: master issues START
i2c_stop  out  1  one-cycle pulse: master issues STOP
i2c_write  out  1  one-cycle pulse: master sends i2c_data
i2c_data  out  8  byte to send, held stable until i2c_done
i2c_busy  in  1  master busy
i2c_done  in  1  one-cycle pulse: current primitive complete
i2c_ack_err  in  1  NACK flag, valid with i2c_done after a write
fb_addr  out  FB_AW  BRAM read address
fb_rdata  in  8  BRAM read data, valid 1 cycle after fb_addr
oled_busy  out  1  transaction in progress
oled_init_done  out  1  init completed; sticky
oled_err  out  1  retries exhausted; sticky until reset

Behaviour:
- Reset (async, active-high): all outputs 0, fb_addr=0, retry count=0, pending=0. FSM enters INIT.
- Primitive rule: a pulse (start/stop/write) is issued only in a cycle with i2c_busy=0. The FSM then waits for i2c_done. There is exactly one primitive outstanding at a time.
- Transaction shape: START, address byte, control byte, payload bytes, STOP.
- INIT: control 0x00. Payload is the INIT_LEN=25 byte ROM: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
  - A8 operand = PAGES*8-1.
  - After STOP done: oled_init_done=1, state READY.
- READY: oled_busy=0. A refresh_req, or a pending refresh, moves to WINDOW.
- WINDOW: control 0x00, payload 21 00 COLS-1 22 00 PAGES-1. Then DATA.
- DATA: control 0x40, payload COLS*PAGES bytes from fb_addr 0..COLS*PAGES-1.
  - fb_addr for byte n+1 is presented while byte n is in flight, so no extra wait states are added.
  - fb_addr returns to 0 at frame end.
- oled_busy=1 in every state except READY and ERROR.
- refresh_req while busy or before init: latched into a one-deep pending flag. Further pulses merge into it. Pending is cleared when WINDOW starts.
- NACK (i2c_done with i2c_ack_err=1 after a write):
  - Issue STOP and increment the retry count.
  - If count <= MAX_RETRY: restart the current transaction from START. For DATA this restarts from byte 0.
  - Otherwise enter ERROR: oled_err=1, oled_busy=0. ERROR is terminal until reset.
  - The retry count clears on each successful transaction.
- i2c_done arriving with no primitive outstanding: ignored.
- Reset mid-frame: immediate return to reset values; init reruns.

Optional Feature:
OLED_AUTO_REFRESH_EN.
- Defined: a free-running counter of width clog2(REFRESH_CYCLES) runs only once oled_init_done=1. It sets pending every REFRESH_CYCLES cycles, in addition to refresh_req.
- Undefined: no counter; frames are sent only on refresh_req.

Decomposition:
- Package oled_pkg: state enum (INIT, READY, WINDOW, DATA, ERROR), phase enum (P_START, P_ADDR, P_CTRL, P_PAYLOAD, P_STOP), control-byte constants CTRL_CMD=8'h00 and CTRL_DATA=8'h40, INIT_LEN, and the window command opcodes.
- Sub-module oled_init_rom: combinational 5-bit index to 8-bit byte, parametrised by PAGES.

Test Plan:
- Reset release with a behavioural master model that ACKs everything -> one START, bytes 78 00 then the 25 ROM bytes, one STOP; oled_init_done=1 afterwards.
- refresh_req after init, BRAM preloaded with addr[7:0] -> window bytes 78 00 21 00 7F 22 00 07, then 78 40 followed by 1024 data bytes 00..FF repeating; oled_busy high throughout, low after final STOP.
- Three refresh_req pulses during init -> exactly one frame streamed after init_done.
- NACK on data byte 500, first attempt only -> STOP, DATA restarts at byte 0, frame completes, oled_err=0.
- Persistent NACK on address byte -> 4 attempts (1+MAX_RETRY), then oled_err=1, oled_busy=0, no further START.
- Reset asserted at data byte 300 -> all outputs 0 in the same cycle; init sequence reruns after release.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame streaming controller.
// Build option OLED_AUTO_REFRESH_EN is consumed by oled_stream_ctrl.
package oled_pkg;

  typedef enum logic [2:0] {
    INIT,
    READY,
    WINDOW,
    DATA,
    ERROR
  } state_e;

  typedef enum logic [2:0] {
    P_START,
    P_ADDR,
    P_CTRL,
    P_PAYLOAD,
    P_STOP
  } phase_e;

  localparam logic [7:0] CTRL_CMD      = 8'h00;
  localparam logic [7:0] CTRL_DATA     = 8'h40;
  localparam int         INIT_LEN      = 25;
  localparam int         WIN_LEN       = 6;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  // Window command: column range 0..col_last, page range 0..page_last.
  function automatic logic [7:0] win_byte(
    input logic [2:0] i,
    input logic [7:0] col_last,
    input logic [7:0] page_last
  );
    logic [7:0] b;
    b = 8'h00;
    case (i)
      3'd0:    b = CMD_COL_ADDR;
      3'd2:    b = col_last;
      3'd3:    b = CMD_PAGE_ADDR;
      3'd5:    b = page_last;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command table; multiplex ratio follows the panel height.
module oled_init_rom
  import oled_pkg::*;
#(
  parameter int PAGES = 8
) (
  input  logic [4:0] idx,
  output logic [7:0] data
);

  localparam logic [7:0] MUX_RATIO = 8'(PAGES * 8 - 1);

  always_comb begin
    data = 8'hE3;
    case (idx)
      5'd0:    data = 8'hAE;
      5'd1:    data = 8'hD5;
      5'd2:    data = 8'h80;
      5'd3:    data = 8'hA8;
      5'd4:    data = MUX_RATIO;
      5'd5:    data = 8'hD3;
      5'd6:    data = 8'h00;
      5'd7:    data = 8'h40;
      5'd8:    data = 8'h8D;
      5'd9:    data = 8'h14;
      5'd10:   data = 8'h20;
      5'd11:   data = 8'h00;
      5'd12:   data = 8'hA1;
      5'd13:   data = 8'hC8;
      5'd14:   data = 8'hDA;
      5'd15:   data = 8'h12;
      5'd16:   data = 8'h81;
      5'd17:   data = 8'hCF;
      5'd18:   data = 8'hD9;
      5'd19:   data = 8'hF1;
      5'd20:   data = 8'hDB;
      5'd21:   data = 8'h40;
      5'd22:   data = 8'hA4;
      5'd23:   data = 8'hA6;
      5'd24:   data = 8'hAF;
      default: data = 8'hE3;
    endcase
  end

endmodule

// File: rtl/oled_stream_ctrl.sv
// SSD1306 init + framebuffer streaming FSM on top of a byte-level I2C master.
// Define OLED_AUTO_REFRESH_EN to add a periodic self-refresh timer.
module oled_stream_ctrl
  import oled_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR       = 7'h3C,
  parameter int         COLS           = 128,
  parameter int         PAGES          = 8,
  parameter int         FB_AW          = 10,
  parameter int         MAX_RETRY      = 3,
  parameter int         REFRESH_CYCLES = 1_666_666
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refresh_req,
  output logic             i2c_start,
  output logic             i2c_stop,
  output logic             i2c_write,
  output logic [7:0]       i2c_data,
  input  logic             i2c_busy,
  input  logic             i2c_done,
  input  logic             i2c_ack_err,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_rdata,
  output logic             oled_busy,
  output logic             oled_init_done,
  output logic             oled_err
);

  localparam int IW    = FB_AW + 1;
  localparam int RW    = $clog2(MAX_RETRY + 2);
  localparam int FRAME = COLS * PAGES;
  localparam bit CFG_OK =
    (FRAME <= 2 ** FB_AW) && (REFRESH_CYCLES > 1);

  localparam logic [IW-1:0] FRAME_LAST = IW'(FRAME - 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_LEN - 1);
  localparam logic [IW-1:0] WIN_LAST   = IW'(WIN_LEN - 1);
  localparam logic [7:0]    COL_LAST   = 8'(COLS - 1);
  localparam logic [7:0]    PAGE_LAST  = 8'(PAGES - 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("oled_stream_ctrl: framebuffer too small");
  end

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              wait_q, wait_d;
  logic              nack_q, nack_d;
  logic              pending_q, pending_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              write_q, write_d;
  logic [7:0]        data_q, data_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;

  logic [7:0]    rom_byte;
  logic [7:0]    payload_byte;
  logic [7:0]    ctrl_byte;
  logic [IW-1:0] payload_last;
  logic          refresh_tick;

  oled_init_rom #(
    .PAGES (PAGES)
  ) u_rom (
    .idx  (idx_q[4:0]),
    .data (rom_byte)
  );

`ifdef OLED_AUTO_REFRESH_EN
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] ref_cnt_q, ref_cnt_d;

  always_comb begin
    ref_cnt_d    = ref_cnt_q;
    refresh_tick = 1'b0;
    if (init_done_q) begin
      if (ref_cnt_q == CNT_LAST) begin
        ref_cnt_d    = '0;
        refresh_tick = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ref_cnt_q <= '0;
    else       ref_cnt_q <= ref_cnt_d;
  end
`else
  assign refresh_tick = 1'b0;
`endif

  always_comb begin
    payload_byte = fb_rdata;
    payload_last = FRAME_LAST;
    ctrl_byte    = CTRL_CMD;
    case (state_q)
      INIT: begin
        payload_byte = rom_byte;
        payload_last = INIT_LAST;
      end
      WINDOW: begin
        payload_byte = win_byte(idx_q[2:0], COL_LAST, PAGE_LAST);
        payload_last = WIN_LAST;
      end
      DATA:    ctrl_byte = CTRL_DATA;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    nack_d      = nack_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    write_d     = 1'b0;
    data_d      = data_q;
    fb_addr_d   = fb_addr_q;
    pending_d   = pending_q | refresh_req | refresh_tick;

    case (state_q)
      READY: begin
        if (pending_q || refresh_req) begin
          state_d   = WINDOW;
          phase_d   = P_START;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      ERROR: ;
      default: begin
        if (wait_q) begin
          // Stray done pulses are only honoured while a primitive is open.
          if (i2c_done) begin
            wait_d = 1'b0;
            unique case (phase_q)
              P_START: phase_d = P_ADDR;
              P_STOP: begin
                phase_d = P_START;
                idx_d   = '0;
                if (nack_q) begin
                  nack_d = 1'b0;
                  if (retry_q > RW'(MAX_RETRY)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                  end
                end else begin
                  retry_d = '0;
                  case (state_q)
                    INIT: begin
                      state_d     = READY;
                      init_done_d = 1'b1;
                    end
                    WINDOW:  state_d = DATA;
                    default: state_d = READY;
                  endcase
                end
              end
              default: begin
                if (i2c_ack_err) begin
                  nack_d    = 1'b1;
                  phase_d   = P_STOP;
                  retry_d   = retry_q + 1'b1;
                  fb_addr_d = '0;
                end else if (phase_q == P_ADDR) begin
                  phase_d = P_CTRL;
                end else if (phase_q == P_CTRL) begin
                  phase_d = P_PAYLOAD;
                  idx_d   = '0;
                end else if (idx_q == payload_last) begin
                  phase_d = P_STOP;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
            endcase
          end
        end else if (!i2c_busy) begin
          wait_d = 1'b1;
          unique case (phase_q)
            P_START: start_d = 1'b1;
            P_ADDR: begin
              write_d = 1'b1;
              data_d  = {I2C_ADDR, 1'b0};
            end
            P_CTRL: begin
              write_d = 1'b1;
              data_d  = ctrl_byte;
            end
            P_PAYLOAD: begin
              write_d = 1'b1;
              data_d  = payload_byte;
              // Prefetch the next pixel byte while this one is on the bus.
              if (state_q == DATA) begin
                if (idx_q == FRAME_LAST) fb_addr_d = '0;
                else fb_addr_d = FB_AW'(idx_q + 1'b1);
              end
            end
            default: stop_d = 1'b1;
          endcase
        end
      end
    endcase

    busy_d = (state_d != READY) && (state_d != ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      phase_q     <= P_START;
      idx_q       <= '0;
      retry_q     <= '0;
      wait_q      <= 1'b0;
      nack_q      <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      write_q     <= 1'b0;
      data_q      <= '0;
      fb_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
      nack_q      <= nack_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      write_q     <= write_d;
      data_q      <= data_d;
      fb_addr_q   <= fb_addr_d;
    end
  end

  assign i2c_start      = start_q;
  assign i2c_stop       = stop_q;
  assign i2c_write      = write_q;
  assign i2c_data       = data_q;
  assign fb_addr        = fb_addr_q;
  assign oled_busy      = busy_q;
  assign oled_init_done = init_done_q;
  assign oled_err       = err_q;

endmodule

// File: tb/tb_oled_stream_ctrl.sv
// Bench for oled_stream_ctrl: behavioural I2C master, BRAM and
// transaction-level expected byte streams.
module tb_oled_stream_ctrl;

  localparam int COLS     = 128;
  localparam int PAGES    = 8;
  localparam int FB_AW    = 10;
  localparam int FRAME    = COLS * PAGES;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 512;
  localparam int ADDR_B   = 8'h78;
  localparam int LIMIT    = 20000;

  localparam logic [7:0] ROM [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'(PAGES * 8 - 1),
    8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
    8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  logic             clk = 1'b0;
  logic             rst;
  logic             refresh_req;
  logic             i2c_start, i2c_stop, i2c_write;
  logic [7:0]       i2c_data;
  logic             i2c_busy;
  logic             m_done, m_nack, spur_done;
  logic             i2c_done, i2c_ack_err;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_rdata;
  logic             oled_busy, oled_init_done, oled_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         log_q[$];
  int         exp_q[$];
  logic [7:0] mem [FRAME];

  int wr_total    = 0;
  int start_total = 0;
  int proto_err   = 0;
  int m_left      = 0;
  bit m_pend_nack = 1'b0;
  int nack_mode   = 0;
  int nack_target = -1;

  assign i2c_done    = m_done | spur_done;
  assign i2c_ack_err = m_nack;

  always #5 clk = ~clk;

  oled_stream_ctrl #(
    .I2C_ADDR       (7'h3C),
    .COLS           (COLS),
    .PAGES          (PAGES),
    .FB_AW          (FB_AW),
    .MAX_RETRY      (3),
    .REFRESH_CYCLES (1_666_666)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .refresh_req    (refresh_req),
    .i2c_start      (i2c_start),
    .i2c_stop       (i2c_stop),
    .i2c_write      (i2c_write),
    .i2c_data       (i2c_data),
    .i2c_busy       (i2c_busy),
    .i2c_done       (i2c_done),
    .i2c_ack_err    (i2c_ack_err),
    .fb_addr        (fb_addr),
    .fb_rdata       (fb_rdata),
    .oled_busy      (oled_busy),
    .oled_init_done (oled_init_done),
    .oled_err       (oled_err)
  );

  always @(posedge clk) fb_rdata <= mem[fb_addr];

  // Master: one primitive at a time, 1-2 cycle latency, scripted NACKs.
  always @(posedge clk) begin
    m_done <= 1'b0;
    m_nack <= 1'b0;
    if (rst) begin
      i2c_busy <= 1'b0;
      m_left = 0;
    end else if (i2c_start || i2c_stop || i2c_write) begin
      if (m_left != 0 || i2c_busy ||
          int'(i2c_start) + int'(i2c_stop) + int'(i2c_write) != 1)
        proto_err++;
      i2c_busy <= 1'b1;
      m_left = $urandom_range(1, 2);
      if (i2c_start) begin
        log_q.push_back(EV_START);
        start_total++;
        m_pend_nack = 1'b0;
      end else if (i2c_stop) begin
        log_q.push_back(EV_STOP);
        m_pend_nack = 1'b0;
      end else begin
        log_q.push_back(int'(i2c_data));
        m_pend_nack = (nack_mode == 1 && wr_total == nack_target) ||
                      (nack_mode == 2 && i2c_data == 8'h78);
        wr_total++;
      end
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done   <= 1'b1;
        m_nack   <= m_pend_nack;
        i2c_busy <= 1'b0;
      end
    end
  end

  function automatic int diff_at(input int base);
    int n;
    n = log_q.size() - base;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= n) return i;
      if (log_q[base + i] != exp_q[i]) return i;
    end
    if (n != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic int got_at(input int base, input int d);
    if (base + d < log_q.size()) return log_q[base + d];
    return -1;
  endfunction

  function automatic int exp_at(input int d);
    if (d < exp_q.size()) return exp_q[d];
    return -1;
  endfunction

  task automatic exp_hdr(input int ctrl);
    exp_q.push_back(EV_START);
    exp_q.push_back(ADDR_B);
    exp_q.push_back(ctrl);
  endtask

  task automatic exp_init();
    exp_hdr(8'h00);
    for (int i = 0; i < 25; i++) exp_q.push_back(int'(ROM[i]));
    exp_q.push_back(EV_STOP);
  endtask

  task automatic exp_window();
    exp_hdr(8'h00);
    exp_q.push_back(8'h21);
    exp_q.push_back(0);
    exp_q.push_back(COLS - 1);
    exp_q.push_back(8'h22);
    exp_q.push_back(0);
    exp_q.push_back(PAGES - 1);
    exp_q.push_back(EV_STOP);
  endtask

  task automatic exp_data(input int nbytes);
    exp_hdr(8'h40);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(int'(mem[i]));
    exp_q.push_back(EV_STOP);
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < FRAME; i++)
      mem[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int cyc;
    cyc = 0;
    while (!oled_init_done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (oled_init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: init_done=%b after %0d cycles, need 1",
               name, oled_init_done, cyc);
    end
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (oled_busy && cyc < 2 * LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (oled_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, need 0",
               name, oled_busy, cyc);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    refresh_req = 1'b0;
    spur_done   = 1'b0;
    fill_mem(1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({i2c_start, i2c_stop, i2c_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b need 000",
               {i2c_start, i2c_stop, i2c_write});
    end
    n_checks++;
    if (i2c_data !== 8'h00 || fb_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_data_addr: got %h/%h need 00/000",
               i2c_data, fb_addr);
    end
    n_checks++;
    if ({oled_busy, oled_init_done, oled_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b need 000",
               {oled_busy, oled_init_done, oled_err});
    end
  endtask

  task automatic test_init();
    int base, st0, d;
    base = log_q.size();
    st0  = start_total;
    exp_q.delete();
    exp_init();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (oled_busy !== 1'b1 || oled_init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_busy: busy/done got %b%b need 10",
               oled_busy, oled_init_done);
    end
    wait_init("init");
    repeat (20) @(negedge clk);
    d = diff_at(base);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL init_seq: event %0d got %0h need %0h",
               d, got_at(base, d), exp_at(d));
    end
    n_checks++;
    if (oled_busy !== 1'b0 || start_total - st0 != 1) begin
      n_fail++;
      $display("FAIL init_idle: busy=%b starts=%0d need 0/1",
               oled_busy, start_total - st0);
    end
  endtask

  task automatic test_frame(input bit rnd);
    int base, d;
    fill_mem(rnd);
    base = log_q.size();
    exp_q.delete();
    exp_window();
    exp_data(FRAME);
    pulse_refresh();
    n_checks++;
    if (oled_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_busy_start: got %b need 1", oled_busy);
    end
    wait_idle("frame");
    d = diff_at(base);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL frame_seq: event %0d got %0h need %0h",
               d, got_at(base, d), exp_at(d));
    end
    n_checks++;
    if (fb_addr !== '0 || oled_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: fb_addr=%0d err=%b need 0/0",
               fb_addr, oled_err);
    end
  endtask

  task automatic test_pending();
    int base, d, late;
    late = 0;
    rst = 1'b1;
    @(negedge clk);
    base = log_q.size();
    rst = 1'b0;
    fill_mem(1'b1);
    exp_q.delete();
    exp_init();
    exp_window();
    exp_data(FRAME);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 30)) @(negedge clk);
      if (oled_init_done) late++;
      pulse_refresh();
    end
    n_checks++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL pending_timing: %0d pulses after init, need 0", late);
    end
    wait_init("pending");
    @(negedge clk);
    wait_idle("pending");
    repeat (100) @(negedge clk);
    d = diff_at(base);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL pending_seq: event %0d got %0h need %0h",
               d, got_at(base, d), exp_at(d));
    end
  endtask

  task automatic test_nack_data(input int k);
    int base, d;
    fill_mem(1'b1);
    base = log_q.size();
    exp_q.delete();
    exp_window();
    exp_data(k + 1);
    exp_data(FRAME);
    nack_target = wr_total + 8 + 2 + k;
    nack_mode   = 1;
    pulse_refresh();
    wait_idle("nack_data");
    nack_mode = 0;
    d = diff_at(base);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL nack_data_seq(k=%0d): event %0d got %0h need %0h",
               k, d, got_at(base, d), exp_at(d));
    end
    n_checks++;
    if (oled_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nack_data_err: got %b need 0", oled_err);
    end
  endtask

  task automatic test_spurious_done();
    int base;
    base = log_q.size();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (log_q.size() != base || oled_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_done: events=%0d busy=%b need 0/0",
               log_q.size() - base, oled_busy);
    end
    test_frame(1'b1);
  endtask

  task automatic test_nack_persist();
    int base, st0, d, cyc;
    base = log_q.size();
    st0  = start_total;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(EV_START);
      exp_q.push_back(ADDR_B);
      exp_q.push_back(EV_STOP);
    end
    nack_mode = 2;
    pulse_refresh();
    cyc = 0;
    while (!oled_err && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    pulse_refresh();
    repeat (200) @(negedge clk);
    nack_mode = 0;
    d = diff_at(base);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL persist_seq: event %0d got %0h need %0h",
               d, got_at(base, d), exp_at(d));
    end
    n_checks++;
    if (oled_err !== 1'b1 || oled_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL persist_status: err/busy got %b%b need 10",
               oled_err, oled_busy);
    end
    n_checks++;
    if (start_total - st0 != 4) begin
      n_fail++;
      $display("FAIL persist_starts: got %0d need 4", start_total - st0);
    end
  endtask

  task automatic test_reset_mid();
    int base, wr0, cyc, d;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init("mid_pre");
    fill_mem(1'b1);
    wr0 = wr_total;
    pulse_refresh();
    cyc = 0;
    while (wr_total < wr0 + 8 + 2 + 301 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (wr_total < wr0 + 311) begin
      n_fail++;
      $display("FAIL mid_reach: writes=%0d need %0d",
               wr_total - wr0, 311);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({i2c_start, i2c_stop, i2c_write, oled_busy,
         oled_init_done, oled_err} !== 6'b0 ||
        i2c_data !== 8'h00 || fb_addr !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ctl=%b data=%h addr=%0d need 0",
               {i2c_start, i2c_stop, i2c_write, oled_busy,
                oled_init_done, oled_err}, i2c_data, fb_addr);
    end
    repeat (2) @(negedge clk);
    base = log_q.size();
    exp_q.delete();
    exp_init();
    rst = 1'b0;
    wait_init("mid_post");
    repeat (20) @(negedge clk);
    d = diff_at(base);
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL mid_reinit_seq: event %0d got %0h need %0h",
               d, got_at(base, d), exp_at(d));
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame(1'b0);
    test_frame(1'b1);
    test_pending();
    test_nack_data(500);
    test_nack_data($urandom_range(0, FRAME - 1));
    test_spurious_done();
    test_nack_persist();
    test_reset_mid();
    n_checks++;
    if (proto_err != 0) begin
      n_fail++;
      $display("FAIL primitive_rule: %0d violations, need 0", proto_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
